// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

  localparam int PC_INCR = 4;
  localparam int INSTR_W = 32;
  localparam int J_IDX_W = 26;
  localparam int IMM_W   = 16;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
// Clear wins over push and pop; pointers wrap modulo BUF_DEPTH (a power of two).
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  localparam int CW       = cnt_width(BUF_DEPTH),
  localparam int PW       = $clog2(BUF_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [XLEN-1:0]    wr_pc,
  input  logic [INSTR_W-1:0] wr_instr,
  output logic [XLEN-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);

  logic [XLEN-1:0]    pc_mem_r    [BUF_DEPTH];
  logic [INSTR_W-1:0] instr_mem_r [BUF_DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               push_s;
  logic               pop_s;

  assign full     = (count_r == CW'(BUF_DEPTH));
  assign empty    = (count_r == CW'(0));
  assign push_s   = push & ~full & ~clear;
  assign pop_s    = pop & ~empty;
  assign count    = count_r;
  assign rd_pc    = pc_mem_r[rd_ptr_r];
  assign rd_instr = instr_mem_r[rd_ptr_r];

  // Storage array: contents are only observed through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= wr_pc;
      instr_mem_r[wr_ptr_r] <= wr_instr;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, talks to imem, buffers toward decode.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_pcplus4,
  input  logic               if_ready,
  input  logic               resolve_valid,
  input  logic [XLEN-1:0]    resolve_pc,
  input  logic [INSTR_W-1:0] resolve_instr,
  input  logic               pcsrc,
  input  logic               jump,
  input  logic               jr,
  input  logic [XLEN-1:0]    jr_target,
  output logic               redirect,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
);

  localparam int CW = cnt_width(BUF_DEPTH);

  fetch_state_e       state_r;
  logic [XLEN-1:0]    pc_r;
  logic               redirect_r;
  logic               accept_s;
  logic               pop_s;
  logic               push_s;
  logic               redir_s;
  logic [XLEN-1:0]    p4_s;
  logic [XLEN-1:0]    br_off_s;
  logic [XLEN-1:0]    target_s;
  logic [CW-1:0]      count_s;
  logic [CW-1:0]      count_next_s;
  logic               full_s;
  logic               empty_s;
  logic [XLEN-1:0]    head_pc_s;
  logic [INSTR_W-1:0] head_instr_s;
  logic               unused_s;

  assign imem_req     = (state_r == FETCH);
  assign imem_addr    = pc_r;
  assign if_valid     = ~empty_s;
  assign accept_s     = imem_req & imem_ready;
  assign pop_s        = if_valid & if_ready;
  assign redir_s      = resolve_valid & (jr | jump | pcsrc);
  assign push_s       = accept_s & ~redir_s;
  assign count_next_s = count_s + CW'(push_s) - CW'(pop_s);
  assign redirect     = redirect_r;
  assign unused_s     = ^{resolve_instr[INSTR_W-1:J_IDX_W], full_s};

  // Head is presented as zeros whenever the buffer is empty.
  assign if_pc      = if_valid ? head_pc_s : '0;
  assign if_instr   = if_valid ? head_instr_s : '0;
  assign if_pcplus4 = if_valid ? head_pc_s + XLEN'(PC_INCR) : '0;

  // Redirect target selection, jr > jump > branch.
  always_comb begin
    p4_s     = resolve_pc + XLEN'(PC_INCR);
    br_off_s = {{(XLEN-IMM_W-2){resolve_instr[IMM_W-1]}}, resolve_instr[IMM_W-1:0], 2'b00};
    if (jr) begin
      target_s = jr_target;
    end else if (jump) begin
      target_s = {p4_s[XLEN-1:28], resolve_instr[J_IDX_W-1:0], 2'b00};
    end else begin
      target_s = p4_s + br_off_s;
    end
  end

  // PC, fetch state machine and redirect pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      redirect_r <= 1'b0;
    end else begin
      redirect_r <= redir_s;
      if (redir_s) begin
        pc_r    <= target_s;
        state_r <= FETCH;
      end else begin
        if (accept_s) pc_r <= pc_r + XLEN'(PC_INCR);
        case (state_r)
          IDLE:    state_r <= FETCH;
          FETCH:   if (count_next_s == CW'(BUF_DEPTH)) state_r <= FULL;
          FULL:    if (pop_s) state_r <= FETCH;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  fetch_buffer #(
    .XLEN      (XLEN),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .pop      (pop_s),
    .clear    (redir_s),
    .wr_pc    (pc_r),
    .wr_instr (imem_rdata),
    .rd_pc    (head_pc_s),
    .rd_instr (head_instr_s),
    .count    (count_s),
    .full     (full_s),
    .empty    (empty_s)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_flushed_r;
  logic [CW-1:0] flush_n_s;

  // Entries lost to a redirect; a same-cycle pop already went to decode.
  assign flush_n_s = count_s - CW'(pop_s);

  // Saturating accept and flush counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_r <= 32'd0;
      perf_flushed_r <= 32'd0;
    end else begin
      if (accept_s) perf_fetched_r <= sat_add32(perf_fetched_r, 32'd1);
      if (redir_s)  perf_flushed_r <= sat_add32(perf_flushed_r, 32'(flush_n_s));
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_flushed = perf_flushed_r;
`else
  assign perf_fetched = 32'd0;
  assign perf_flushed = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default instance (depth 2) and a wrap/flush
// instance (RESET_PC=0xFFFFFFFC, depth 4) sharing stimulus, each with its own reset.
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, b_reset, ir, dr, rv, pcsrc, jump, jr;
  logic [31:0] rpc, rinstr, jrt;
  logic        a_req, a_valid, a_redir, b_req, b_valid, b_redir;
  logic [31:0] a_addr, a_rdata, a_instr, a_pc, a_pc4, a_pf, a_pfl;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_pc4, b_pf, b_pfl;

  // Instruction memory model: word content derived from the address.
  assign a_rdata = 32'hA000_0000 | a_addr;
  assign b_rdata = 32'hA000_0000 | b_addr;

  fetch_unit u_a (
    .clk(clk), .reset(a_reset), .imem_req(a_req), .imem_addr(a_addr),
    .imem_ready(ir), .imem_rdata(a_rdata), .if_valid(a_valid), .if_instr(a_instr),
    .if_pc(a_pc), .if_pcplus4(a_pc4), .if_ready(dr), .resolve_valid(rv),
    .resolve_pc(rpc), .resolve_instr(rinstr), .pcsrc(pcsrc), .jump(jump), .jr(jr),
    .jr_target(jrt), .redirect(a_redir), .perf_fetched(a_pf), .perf_flushed(a_pfl)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(4)) u_b (
    .clk(clk), .reset(b_reset), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(ir), .imem_rdata(b_rdata), .if_valid(b_valid), .if_instr(b_instr),
    .if_pc(b_pc), .if_pcplus4(b_pc4), .if_ready(dr), .resolve_valid(rv),
    .resolve_pc(rpc), .resolve_instr(rinstr), .pcsrc(pcsrc), .jump(jump), .jr(jr),
    .jr_target(jrt), .redirect(b_redir), .perf_fetched(b_pf), .perf_flushed(b_pfl)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          rst;
    bit          ir;
    bit          dr;
    bit          req;
    logic [31:0] addr;
    bit          v;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_resolve();
    rv = 1'b0; pcsrc = 1'b0; jump = 1'b0; jr = 1'b0;
    rpc = 32'd0; rinstr = 32'd0; jrt = 32'd0;
  endtask

  task automatic reset_a();
    a_reset = 1'b0;
    step();
    step();
    chk("a_rst_req", a_req, 32'd0);
    chk("a_rst_valid", a_valid, 32'd0);
    chk("a_rst_redir", a_redir, 32'd0);
    chk("a_rst_addr", a_addr, 32'd0);
    chk("a_rst_instr", a_instr, 32'd0);
    chk("a_rst_pc", a_pc, 32'd0);
    chk("a_rst_pc4", a_pc4, 32'd0);
    chk("a_rst_perf", a_pf | a_pfl, 32'd0);
    a_reset = 1'b1;
  endtask

  task automatic chk_head_a(input string tag, input bit v, input logic [31:0] pc);
    chk({tag, "_valid"}, a_valid, 32'(v));
    chk({tag, "_pc"}, a_pc, v ? pc : 32'd0);
    chk({tag, "_pc4"}, a_pc4, v ? pc + 32'd4 : 32'd0);
    chk({tag, "_instr"}, a_instr, v ? (32'hA000_0000 | pc) : 32'd0);
  endtask

  initial begin
    a_reset = 1'b0; b_reset = 1'b0; ir = 1'b0; dr = 1'b0;
    clear_resolve();

    //           rst  ir  dr  req  addr        v   pc
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 1'b1, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 1'b1, 32'h0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hC, 1'b1, 32'h4};

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) reset_a();
      ir = tbl[i].ir;
      dr = tbl[i].dr;
      step();
      chk($sformatf("r%0d_req", i), a_req, 32'(tbl[i].req));
      chk($sformatf("r%0d_addr", i), a_addr, tbl[i].addr);
      chk_head_a($sformatf("r%0d", i), tbl[i].v, tbl[i].pc);
    end

    // Taken branch while full: 0x104 + (-2 << 2) = 0xFC, buffer flushed.
    ir = 1'b1; dr = 1'b0;
    rv = 1'b1; pcsrc = 1'b1; rpc = 32'h100; rinstr = 32'h0000_FFFE;
    step();
    chk("br_addr", a_addr, 32'h0000_00FC);
    chk("br_req", a_req, 32'd1);
    chk("br_valid", a_valid, 32'd0);
    chk("br_redir", a_redir, 32'd1);
    clear_resolve();
    ir = 1'b0;
    step();
    chk("br_redir_pulse", a_redir, 32'd0);
    chk("br_addr_hold", a_addr, 32'h0000_00FC);
    ir = 1'b1;
    step();
    chk("br_after_addr", a_addr, 32'h0000_0100);
    chk_head_a("br_after", 1'b1, 32'h0000_00FC);

    // jr and jump together: jr wins; then jump alone.
    ir = 1'b0;
    rv = 1'b1; jump = 1'b1; jr = 1'b1; jrt = 32'h2000;
    rpc = 32'h3000_0010; rinstr = 32'h0000_0040;
    step();
    chk("jr_prio_addr", a_addr, 32'h0000_2000);
    chk("jr_prio_redir", a_redir, 32'd1);
    jr = 1'b0;
    step();
    chk("jump_addr", a_addr, 32'h3000_0100);
    jump = 1'b0;
    step();
    chk("noctl_addr", a_addr, 32'h3000_0100);
    chk("noctl_redir", a_redir, 32'd0);
    rv = 1'b0; pcsrc = 1'b1;
    step();
    chk("novalid_addr", a_addr, 32'h3000_0100);
    chk("novalid_redir", a_redir, 32'd0);
    clear_resolve();

    // Second instance: wrap from 0xFFFFFFFC, redirect discarding a live accept.
    a_reset = 1'b0;
    ir = 1'b1; dr = 1'b0;
    step();
    chk("b_rst_addr", b_addr, 32'hFFFF_FFFC);
    chk("b_rst_req", b_req, 32'd0);
    b_reset = 1'b1;
    step();
    chk("b_first_addr", b_addr, 32'hFFFF_FFFC);
    chk("b_first_req", b_req, 32'd1);
    step();
    chk("b_wrap_addr", b_addr, 32'h0000_0000);
    chk("b_wrap_pc", b_pc, 32'hFFFF_FFFC);
    chk("b_wrap_pc4", b_pc4, 32'h0000_0000);
    step();
    chk("b_third_addr", b_addr, 32'h0000_0004);
    rv = 1'b1; jr = 1'b1; jrt = 32'h40;
    step();
    chk("b_redir_addr", b_addr, 32'h0000_0040);
    chk("b_redir_valid", b_valid, 32'd0);
    chk("b_redir_pulse", b_redir, 32'd1);
    chk("b_perf_fetched", b_pf, PERF ? 32'd3 : 32'd0);
    chk("b_perf_flushed", b_pfl, PERF ? 32'd2 : 32'd0);
    clear_resolve();
    step();
    chk("b_post_addr", b_addr, 32'h0000_0044);
    chk("b_post_valid", b_valid, 32'd1);
    chk("b_post_pc", b_pc, 32'h0000_0040);
    chk("b_post_instr", b_instr, 32'hA000_0040);
    chk("b_post_fetched", b_pf, PERF ? 32'd4 : 32'd0);

    // Asynchronous reset between clock edges.
    #3;
    b_reset = 1'b0;
    #1;
    chk("b_async_req", b_req, 32'd0);
    chk("b_async_valid", b_valid, 32'd0);
    chk("b_async_addr", b_addr, 32'hFFFF_FFFC);
    chk("b_async_perf", b_pf | b_pfl, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
